mem_block_writer: RTL and testbench
===================================

MEM_BLOCK_WRITER -- requirements
Module: mem_block_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the word-count width.
REQ-004 The block SHALL have port mclk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin a block write; sampled only in IDLE or DONE.
REQ-007 The block SHALL have port n, input, CNT_W bits: the number of words to write, latched on start.
REQ-008 The block SHALL have port startaddr, input, ADDR_W bits: the first write address, latched on start.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: the source word.
REQ-010 The block SHALL have port in_valid, input, 1 bit: the source offers in_data.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: the memory write address.
REQ-013 The block SHALL have port mem_din, output, DATA_W bits: the memory write data.
REQ-014 The block SHALL have port mem_we, output, 1 bit: the memory write enable, one word per high cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: high in WRITE and FLUSH.
REQ-016 The block SHALL have port done, output, 1 bit: level, high in DONE.
REQ-017 The block SHALL have port count, output, CNT_W bits: the number of words accepted in the current or last block.

Function
REQ-018 The state machine SHALL have the states IDLE, WRITE, FLUSH and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL latch n and startaddr, clear count, and go to WRITE; if n=0 it SHALL go directly to DONE with no writes.
REQ-020 in_ready SHALL equal 1 only in WRITE with count < latched n.
REQ-021 A handshake is in_valid=1 and in_ready=1; on a handshake the block SHALL register mem_din=in_data, mem_addr=current address and mem_we=1 for exactly the next cycle, then increment count and the address.
REQ-022 Write latency SHALL be one cycle from the handshake edge to mem_we high; back-to-back handshakes SHALL produce back-to-back writes at consecutive addresses.
REQ-023 The address SHALL wrap modulo 2^ADDR_W (16'hFFFF is followed by 16'h0000).
REQ-024 On the handshake that makes count = n, the block SHALL go to FLUSH; FLUSH SHALL last one cycle (the final mem_we) and then go to DONE.
REQ-025 In_valid=0 in WRITE SHALL stall the block with no write and no state change.
REQ-026 done SHALL stay high in DONE until start=1 is accepted; done and busy SHALL never be high together.
REQ-027 start asserted in WRITE or FLUSH SHALL be ignored, and n and startaddr changes during WRITE or FLUSH SHALL have no effect.
REQ-028 mem_we SHALL be 0 in IDLE and DONE, and mem_addr/mem_din SHALL hold their last values when mem_we=0.

Reset
REQ-029 reset=1 at a rising mclk edge SHALL force IDLE and clear in_ready, mem_we, busy, done, count, mem_addr, mem_din and the checksum to 0.
REQ-030 Reset SHALL take priority over every other input, including start and a handshake in the same cycle.
REQ-031 Reset during WRITE or FLUSH SHALL abort the block; no further writes SHALL occur, and a pending registered write SHALL be dropped.

Configuration
REQ-032 With macro WRITE_CHECKSUM_EN defined, the block SHALL provide output checksum, DATA_W bits: the modulo-2^DATA_W sum of all words accepted since the last start, cleared on start and valid while done=1.
REQ-033 With WRITE_CHECKSUM_EN undefined, the checksum port and its adder SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Bench: reset, then start with n=2, startaddr=0, words 16'h0878 and 16'h0011 with valid held high -> writes to addr 0 and 1 on consecutive cycles, done=1, count=2, checksum=16'h0889.
REQ-035 Bench: start with n=4, startaddr=16'h16, in_valid toggled 1/0 -> exactly 4 writes at 16'h16..16'h19, no write on stall cycles, done only after the 4th write.
REQ-036 Bench: start with n=3, startaddr=16'hFFFE -> writes at 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-037 Bench: start with n=0 -> done=1 within 2 cycles, mem_we never high, count=0.
REQ-038 Bench: start with n=8, assert reset after the 3rd handshake -> exactly 3 writes, and next cycle all outputs are 0 in IDLE.
REQ-039 Bench: pulse start while busy during an n=4 block -> block completes unchanged; a second start from DONE begins a new block and clears done.

Source files
------------

// File: rtl/mem_block_writer.sv
// mem_block_writer
// Accepts a block of n words on a valid/ready stream and writes them to
// consecutive memory addresses starting at startaddr. Each accepted word
// appears on the memory write port one cycle after its handshake. The
// address wraps modulo 2^ADDR_W.
//
// Optional feature: define WRITE_CHECKSUM_EN to add the `checksum` output.
// This output carries the modulo-2^DATA_W sum of the words accepted since
// the last start.
module mem_block_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n,
  input  logic [ADDR_W-1:0] startaddr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
`ifdef WRITE_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Registered state
  state_t              state_r;
  logic [CNT_W-1:0]    n_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]    count_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_din_r;
  logic                mem_we_r;
  logic                in_ready_r;
  logic                busy_r;
  logic                done_r;

  // Next-state values
  state_t              state_s;
  logic [CNT_W-1:0]    n_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [CNT_W-1:0]    count_s;
  logic [CNT_W-1:0]    count_inc_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_din_s;
  logic                mem_we_s;
  logic                in_ready_s;
  logic                busy_s;
  logic                done_s;
  logic                handshake_s;
  logic                start_acc_s;

  // Handshake and start-acceptance qualifiers shared by the FSM and checksum
  always_comb begin
    handshake_s = in_valid && in_ready_r;
    start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    addr_s      = addr_r;
    count_s     = count_r;
    count_inc_s = count_r + CNT_ONE;
    mem_addr_s  = mem_addr_r;
    mem_din_s   = mem_din_r;
    mem_we_s    = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          n_s     = n;
          addr_s  = startaddr;
          count_s = CNT_ZERO;
          if (n == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WRITE: begin
        if (handshake_s) begin
          // Register the word for a write in the following cycle.
          mem_we_s   = 1'b1;
          mem_addr_s = addr_r;
          mem_din_s  = in_data;
          count_s    = count_inc_s;
          addr_s     = addr_r + ADDR_ONE;
          if (count_inc_s == n_r) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_FLUSH: begin
        // The final write is on the port during this cycle.
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they are
    // registered alongside it.
    busy_s     = (state_s == ST_WRITE) || (state_s == ST_FLUSH);
    done_s     = (state_s == ST_DONE);
    in_ready_s = (state_s == ST_WRITE) && (count_s < n_s);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      n_r        <= CNT_ZERO;
      addr_r     <= ADDR_ZERO;
      count_r    <= CNT_ZERO;
      mem_addr_r <= ADDR_ZERO;
      mem_din_r  <= DATA_ZERO;
      mem_we_r   <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      n_r        <= n_s;
      addr_r     <= addr_s;
      count_r    <= count_s;
      mem_addr_r <= mem_addr_s;
      mem_din_r  <= mem_din_s;
      mem_we_r   <= mem_we_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign in_ready = in_ready_r;
  assign mem_addr = mem_addr_r;
  assign mem_din  = mem_din_r;
  assign mem_we   = mem_we_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;

`ifdef WRITE_CHECKSUM_EN
  logic [DATA_W-1:0] cks_r;
  logic [DATA_W-1:0] cks_s;

  // Modulo-2^DATA_W accumulate of one accepted word
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction

  // Checksum next value: clear on an accepted start, add on each handshake
  always_comb begin
    cks_s = cks_r;
    if (start_acc_s) begin
      cks_s = DATA_ZERO;
    end else if (handshake_s) begin
      cks_s = csum_add(cks_r, in_data);
    end else begin
      cks_s = cks_r;
    end
  end

  // Checksum register with synchronous reset
  always_ff @(posedge mclk) begin
    if (reset) begin
      cks_r <= DATA_ZERO;
    end else begin
      cks_r <= cks_s;
    end
  end

  assign checksum = cks_r;
`endif

endmodule

// File: tb/tb_mem_block_writer.sv
// Randomized scoreboard bench for mem_block_writer.
// The driver models each block at the transaction level: which words are
// accepted, and at which addresses they must land. It queues the expected
// writes, and an independent monitor pops and compares them whenever mem_we
// is seen high.
module tb_mem_block_writer;
  logic        mclk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  n;
  logic [15:0] startaddr;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [7:0]  count;
`ifdef WRITE_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_block_writer #(.DATA_W(16), .ADDR_W(16), .CNT_W(8)) dut (
    .mclk(mclk), .reset(reset), .start(start), .n(n), .startaddr(startaddr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .busy(busy), .done(done),
`ifdef WRITE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count)
  );

  always #5 mclk = ~mclk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [15:0] last_addr = 16'd0;
  logic [15:0] last_din = 16'd0;
  bit          mon_en = 1'b0;
  logic [15:0] blk_words[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue; with no
  // write, the memory port must hold its previous values.
  always @(negedge mclk) begin
    if (mon_en) begin
      check("done_busy_excl", {31'd0, done & busy}, 32'd0);
      if (mem_we === 1'b1) begin
        check("we_while_busy", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                   mem_addr, mem_din);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {16'd0, mem_addr}, {16'd0, mon_e[31:16]});
          check("wr_data", {16'd0, mem_din}, {16'd0, mon_e[15:0]});
        end
        last_addr = mem_addr;
        last_din  = mem_din;
      end else begin
        check("we_low", {31'd0, mem_we}, 32'd0);
        check("hold_addr", {16'd0, mem_addr}, {16'd0, last_addr});
        check("hold_din", {16'd0, mem_din}, {16'd0, last_din});
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_all_zero();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {24'd0, count}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_din", {16'd0, mem_din}, 32'd0);
`ifdef WRITE_CHECKSUM_EN
    check("rst_checksum", {16'd0, checksum}, 32'd0);
`endif
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    exp_q.delete();
    last_addr = 16'd0;
    last_din = 16'd0;
    check_all_zero();
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic fill_random(input int nn);
    for (int i = 0; i < nn; i++) blk_words[i] = 16'($urandom);
  endtask

  // mode: 0 valid held high, 1 valid toggles 1/0, 2 random valid.
  // abort_after > 0 asserts reset in the cycle after that many handshakes.
  task automatic run_block(input int nn, input logic [15:0] sa, input int mode,
                           input int abort_after, input bit pulse_busy);
    int acc;
    bit v;
    bit finished;
    logic [15:0] sum;
    acc = 0;
    sum = 16'd0;
    finished = 1'b0;
    start = 1'b1;
    n = 8'(nn);
    startaddr = sa;
    tick();
    start = 1'b0;
    n = 8'($urandom);
    startaddr = 16'($urandom);
    if (nn == 0) begin
      check("n0_done", {31'd0, done}, 32'd1);
      check("n0_busy", {31'd0, busy}, 32'd0);
      check("n0_count", {24'd0, count}, 32'd0);
      check("n0_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef WRITE_CHECKSUM_EN
      check("n0_checksum", {16'd0, checksum}, 32'd0);
`endif
      tick();
      check("n0_done_hold", {31'd0, done}, 32'd1);
      return;
    end
    for (int cyc = 0; cyc < 4 * nn + 40 && !finished; cyc++) begin
      check("in_ready", {31'd0, in_ready}, 32'd1);
      check("busy", {31'd0, busy}, 32'd1);
      check("done_low", {31'd0, done}, 32'd0);
      check("count_run", {24'd0, count}, 32'(acc));
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (abort_after > 0 && acc == abort_after) begin
        v = 1'b1;
        reset = 1'b1;
      end
      in_valid = v;
      in_data = v ? blk_words[acc] : 16'($urandom);
      if (pulse_busy && cyc == 1) begin
        start = 1'b1;
        n = 8'($urandom_range(1, 255));
        startaddr = 16'($urandom);
      end
      if (v && !reset) begin
        exp_q.push_back({sa + 16'(acc), blk_words[acc]});
        sum = sum + blk_words[acc];
        acc++;
      end
      tick();
      start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        in_valid = 1'b0;
        last_addr = 16'd0;
        last_din = 16'd0;
        check("abort_writes_left", 32'(exp_q.size()), 32'd0);
        check_all_zero();
        exp_q.delete();
        tick();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_idle_done", {31'd0, done}, 32'd0);
        return;
      end
      if (acc == nn) finished = 1'b1;
    end
    in_valid = 1'b0;
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL block_timeout: actual accepted=%0d required=%0d", acc, nn);
      return;
    end
    check("flush_busy", {31'd0, busy}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    if (pulse_busy) begin
      start = 1'b1;
      n = 8'($urandom_range(1, 255));
    end
    tick();
    start = 1'b0;
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_in_ready", {31'd0, in_ready}, 32'd0);
    check("end_count", {24'd0, count}, 32'(nn));
    check("end_writes_left", 32'(exp_q.size()), 32'd0);
`ifdef WRITE_CHECKSUM_EN
    check("end_checksum", {16'd0, checksum}, {16'd0, sum});
`endif
    tick();
    check("done_hold", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n = 8'd0;
    startaddr = 16'd0;
    in_data = 16'd0;
    in_valid = 1'b0;
    apply_reset();

    // Two words with valid held high
    blk_words[0] = 16'h0878;
    blk_words[1] = 16'h0011;
    run_block(2, 16'h0000, 0, 0, 1'b0);

    // Stalls on alternate cycles
    fill_random(4);
    run_block(4, 16'h0016, 1, 0, 1'b0);

    // Address wrap
    fill_random(3);
    run_block(3, 16'hFFFE, 0, 0, 1'b0);

    // Empty block
    run_block(0, 16'h1234, 0, 0, 1'b0);

    // Start pulses while busy are ignored; the next start from DONE restarts
    fill_random(4);
    run_block(4, 16'($urandom), 2, 0, 1'b1);
    fill_random(3);
    run_block(3, 16'($urandom), 0, 0, 1'b0);

    // Reset after the third handshake
    fill_random(8);
    run_block(8, 16'h0100, 0, 3, 1'b0);

    // Randomized blocks
    for (int k = 0; k < 25; k++) begin
      int nn;
      logic [15:0] sa;
      nn = $urandom_range(0, 12);
      sa = (k % 4 == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      fill_random(nn);
      run_block(nn, sa, 2, 0, 1'($urandom_range(0, 1)));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
